prj_processor_cpu_mul_iter: RTL and testbench

- Parametrised iterative multiplier for the CPU's M-stage multiply path; the next generation of the fixed three-product 16x16 multiply cell.
- Reuses one SLICE_W x SLICE_W unsigned multiplier to accumulate all partial products of a DATA_W x DATA_W multiply, then applies a signedness correction.
- Supports the full Nios II multiply set: MUL, MULXUU, MULXSU, MULXSS. Returns either the low or the high DATA_W half of the 2*DATA_W product.
- Uses a valid/ready handshake and a pipeline flush.

---
 rtl/prj_processor_cpu_mul_iter.sv | 134 +++++++++++++
 tb/tb_prj_processor_cpu_mul_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prj_processor_cpu_mul_iter.sv
// Iterative DATA_W x DATA_W multiplier built on one shared SLICE_W x SLICE_W unsigned slice.
// Accumulates all partial products, then applies a signedness correction for MULXSU/MULXSS.
module prj_processor_cpu_mul_iter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [1:0]        op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    localparam int unsigned N    = DATA_W / SLICE_W;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AccW = 2 * DATA_W;
    localparam int unsigned PpW  = 2 * SLICE_W;
    localparam logic [CntW-1:0] Last = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StMult, StCorr, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   i_q, i_d, j_q, j_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [SLICE_W-1:0] a_slice, b_slice;
    logic [PpW-1:0]     pp;
    logic [AccW-1:0]    pp_ext;
    logic [AccW-1:0]    corr;
    logic               accept;

    assign a_slice = a_q[SLICE_W*int'(i_q) +: SLICE_W];
    assign b_slice = b_q[SLICE_W*int'(j_q) +: SLICE_W];
    assign pp      = PpW'(a_slice) * PpW'(b_slice);
    assign pp_ext  = AccW'(pp) << (SLICE_W * (int'(i_q) + int'(j_q)));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        i_d      = i_q;
        j_d      = j_q;
        result_d = result_q;
        corr     = acc_q;
        in_ready = 1'b0;
        accept   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                accept   = in_valid && !flush;
            end
            StMult: begin
                acc_d = acc_q + pp_ext;
                if (i_q == Last) begin
                    i_d = '0;
                    if (j_q == Last) begin
                        j_d     = '0;
                        state_d = StCorr;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StCorr: begin
                // Unsigned product minus the weight of each negative operand's sign bit.
                if (op_q[1] && a_q[DATA_W-1]) corr = corr - {b_q, {DATA_W{1'b0}}};
                if (op_q == 2'b11 && b_q[DATA_W-1]) corr = corr - {a_q, {DATA_W{1'b0}}};
                result_d = (op_q == 2'b00) ? corr[DATA_W-1:0] : corr[AccW-1:DATA_W];
                state_d  = StDone;
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = StIdle;
                    accept  = in_valid && !flush;
                end
            end
        endcase

        if (accept) begin
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = StMult;
        end

        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            j_q      <= j_d;
            result_q <= result_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;

endmodule

// File: tb/tb_prj_processor_cpu_mul_iter.sv
// Directed bench for the iterative multiplier: 32-bit corner vectors, handshake, flush and reset,
// plus a 64-bit instance checked against a wide signed/unsigned reference product.
module tb_prj_processor_cpu_mul_iter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] src_a, src_b, result;
    logic [1:0]  op;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, busy64;
    logic [63:0] src_a64, src_b64, result64;
    logic [1:0]  op64;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt;
    logic seen;

    prj_processor_cpu_mul_iter #(.DATA_W(32), .SLICE_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .op(op), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    prj_processor_cpu_mul_iter #(.DATA_W(64), .SLICE_W(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .src_a(src_a64), .src_b(src_b64), .op(op64), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready64), .result(result64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Accept one op, check latency/result, optionally stall the consumer, then drain.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [31:0] exp, input int hold, input string name);
        int c;
        out_ready = 1'b0;
        src_a = a; src_b = b; op = o; in_valid = 1'b1;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0;
        src_a = ~a; src_b = ~b; op = ~o;
        c = 0;
        while (!out_valid && c < 40) begin tick; c++; end
        check({name, " latency"}, 64'(c), 64'd5);
        check({name, " result"}, 64'(result), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            tick;
            check({name, " hold"}, 64'({out_valid, result}), 64'({1'b1, exp}));
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({name, " drop"}, 64'({busy, out_valid}), 64'd0);
    endtask

    function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] o);
        logic [127:0] ea, eb, p;
        ea = o[1] ? {{64{a[63]}}, a} : {64'd0, a};
        eb = (o == 2'b11) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic do_op64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] o);
        int c;
        logic [63:0] exp;
        exp = ref64(a, b, o);
        src_a64 = a; src_b64 = b; op64 = o; in_valid64 = 1'b1;
        tick;
        in_valid64 = 1'b0;
        c = 0;
        while (!out_valid64 && c < 60) begin tick; c++; end
        check("w64 latency", 64'(c), 64'd17);
        check($sformatf("w64 op%0d %h*%h", o, a, b), result64, exp);
        out_ready64 = 1'b1;
        tick;
        out_ready64 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; src_a = '0; src_b = '0; op = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; src_a64 = '0; src_b64 = '0; op64 = '0;
        #12;
        check("reset state", 64'({busy, out_valid, result}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, 0, "ones MUL");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 0, "ones MULXUU");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, 0, "ones MULXSU");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000, 0, "ones MULXSS");
        do_op(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, 0, "min MULXUU");
        do_op(32'h80000000, 32'h80000000, 2'b11, 32'h40000000, 0, "min MULXSS");
        do_op(32'h80000000, 32'h80000000, 2'b10, 32'hC0000000, 0, "min MULXSU");
        do_op(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, 0, "min MUL");
        do_op(32'h00012345, 32'h00010000, 2'b00, 32'h23450000, 10, "stall MUL");

        // Back-to-back: in_valid held, second op taken on the first op's DONE edge.
        out_ready = 1'b1; in_valid = 1'b1;
        src_a = 32'h3; src_b = 32'h5; op = 2'b00;
        tick;
        src_a = 32'hFFFFFFFE; src_b = 32'h2; op = 2'b11;
        cnt = 0;
        while (!out_valid && cnt < 40) begin tick; cnt++; end
        check("b2b op1 latency", 64'(cnt), 64'd5);
        check("b2b op1 result", 64'(result), 64'h0000000F);
        tick;
        check("b2b op2 accepted", 64'({busy, out_valid}), 64'b10);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin tick; cnt++; end
        check("b2b op2 latency", 64'(cnt), 64'd5);
        check("b2b op2 result", 64'(result), 64'hFFFFFFFF);
        tick;
        out_ready = 1'b0;
        check("b2b idle", 64'({busy, out_valid}), 64'd0);

        // Flush during the second MULT cycle; result keeps its previous value.
        src_a = 32'h1; src_b = 32'h1; op = 2'b00; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush state", 64'({busy, out_valid}), 64'd0);
        check("flush keeps result", 64'(result), 64'hFFFFFFFF);
        seen = 1'b0;
        repeat (10) begin tick; seen |= out_valid; end
        check("flush no out_valid", 64'(seen), 64'd0);
        do_op(32'h7, 32'h6, 2'b00, 32'h0000002A, 0, "after flush");

        // Asynchronous reset mid-MULT.
        src_a = 32'h9; src_b = 32'h9; op = 2'b00; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        check("async reset", 64'({busy, out_valid, result}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        check("in_ready after mid reset", 64'(in_ready), 64'd1);
        do_op(32'h0000FFFF, 32'h0000FFFF, 2'b00, 32'hFFFE0001, 0, "after reset");

        // 64-bit instance: corners plus random vectors.
        do_op64(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2'b10);
        do_op64(64'h8000000000000000, 64'h8000000000000000, 2'b11);
        for (int k = 0; k < 8; k++) begin
            do_op64({$urandom, $urandom}, {$urandom, $urandom}, 2'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
